instruction_memory_responder: RTL and testbench

Memory-side responder for the basic-block instruction fetch interface: memory_valid/memory_addr from the requester, memory_ready/memory_data from this block. It serves NUM_PORTS basic blocks from one shared synchronous instruction RAM. Grants are round-robin, pipelined at up to one grant per cycle. A host write port loads the regex program before or between runs.

---
 rtl/instruction_memory_responder_pkg.sv | 16 +
 rtl/instruction_memory_responder_rr_arbiter.sv | 40 ++++
 rtl/instruction_memory_responder.sv | 60 ++++++
 tb/tb_instruction_memory_responder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_memory_responder_pkg.sv
// instruction_memory_responder_pkg: shared fetch-interface widths and regex opcode encoding.
package instruction_memory_responder_pkg;
   localparam int INSTR_WIDTH = 16;
   localparam int INSTR_ADDR_WIDTH = 11;
   localparam int OPCODE_WIDTH = 8;
   typedef enum logic [OPCODE_WIDTH-1:0] {
      OP_CHAR  = 8'h00,
      OP_MATCH = 8'h01,
      OP_JMP   = 8'h02,
      OP_SPLIT = 8'h03,
      OP_ANY   = 8'h04
   } opcode_t;
   function automatic logic [INSTR_WIDTH-1:0] make_instr(input opcode_t op, input logic [INSTR_WIDTH-OPCODE_WIDTH-1:0] operand);
      return {op, operand};
   endfunction
endpackage

// File: rtl/instruction_memory_responder_rr_arbiter.sv
// instruction_memory_responder_rr_arbiter: round-robin pick among unmasked requests, pointer moves past each accepted winner.
module instruction_memory_responder_rr_arbiter
   import instruction_memory_responder_pkg::*;
#(
   parameter int NUM_PORTS = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_PORTS-1:0] request,
   input  logic [NUM_PORTS-1:0] mask,
   input  logic                 advance,
   output logic [NUM_PORTS-1:0] grant,
   output logic                 grant_valid
);
   localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
   logic [PW-1:0] ptr;
   logic [PW-1:0] win;
   logic [NUM_PORTS-1:0] eligible;
   int idx;
   assign eligible = request & ~mask;
   always_comb begin
      grant = '0;
      grant_valid = 1'b0;
      win = '0;
      idx = 0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         idx = (int'(ptr) + k) % NUM_PORTS;
         if (!grant_valid && eligible[idx]) begin
            grant_valid = 1'b1;
            grant[idx] = 1'b1;
            win = PW'(idx);
         end
      end
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset)
         ptr <= '0;
      else if (advance && grant_valid)
         ptr <= (int'(win) == NUM_PORTS - 1) ? '0 : win + 1'b1;
endmodule

// File: rtl/instruction_memory_responder.sv
// instruction_memory_responder: serves NUM_PORTS instruction fetch ports from one shared synchronous RAM,
// round-robin grants, ready one cycle after the request and data one cycle after ready.
module instruction_memory_responder
   import instruction_memory_responder_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int MEMORY_WIDTH = INSTR_WIDTH,
   parameter int MEMORY_ADDR_WIDTH = INSTR_ADDR_WIDTH,
   parameter int MEMORY_DEPTH = 2048
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [NUM_PORTS-1:0]                   memory_valid,
   input  logic [NUM_PORTS*MEMORY_ADDR_WIDTH-1:0] memory_addr,
   output logic [NUM_PORTS-1:0]                   memory_ready,
   output logic [NUM_PORTS*MEMORY_WIDTH-1:0]      memory_data,
   input  logic                                   write_enable,
   input  logic [MEMORY_ADDR_WIDTH-1:0]           write_addr,
   input  logic [MEMORY_WIDTH-1:0]                write_data
);
   localparam int DW = MEMORY_DEPTH > 1 ? $clog2(MEMORY_DEPTH) : 1;
   logic [MEMORY_WIDTH-1:0] ram [MEMORY_DEPTH];
   logic [MEMORY_WIDTH-1:0] rd_data;
   logic [MEMORY_ADDR_WIDTH-1:0] rd_addr;
   logic [NUM_PORTS-1:0] arb_grant;
   logic [NUM_PORTS-1:0] next_grant;
   logic arb_valid;
   logic rd_oob;
   instruction_memory_responder_rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr_arbiter (
      .clk         (clk),
      .reset       (reset),
      .request     (memory_valid),
      .mask        (memory_ready),
      .advance     (!write_enable),
      .grant       (arb_grant),
      .grant_valid (arb_valid)
   );
   // host writes own the RAM port for the cycle, so requests simply wait
   assign next_grant = (arb_valid && !write_enable) ? arb_grant : '0;
   always_comb begin
      rd_addr = '0;
      for (int i = 0; i < NUM_PORTS; i++)
         if (arb_grant[i]) rd_addr = memory_addr[i*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
   end
   always_ff @(posedge clk) begin
      if (write_enable && 32'(write_addr) < MEMORY_DEPTH) ram[write_addr[DW-1:0]] <= write_data;
      if (|next_grant) rd_data <= ram[rd_addr[DW-1:0]];
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         memory_ready <= '0;
         memory_data <= '0;
         rd_oob <= 1'b0;
      end else begin
         memory_ready <= next_grant;
         rd_oob <= 32'(rd_addr) >= MEMORY_DEPTH;
         for (int i = 0; i < NUM_PORTS; i++)
            if (memory_ready[i]) memory_data[i*MEMORY_WIDTH +: MEMORY_WIDTH] <= rd_oob ? '0 : rd_data;
      end
endmodule

// File: tb/tb_instruction_memory_responder.sv
// tb_instruction_memory_responder: directed vector table, hand-written corner sequences and
// randomized traffic checked against a cycle-level behavioural model of the responder.
module tb_instruction_memory_responder;
   import instruction_memory_responder_pkg::*;
   localparam int N = 2;
   localparam int W = 16;
   localparam int AW = 11;
   localparam int DEPTH = 1024;
   localparam logic [W-1:0] SPLIT_W = make_instr(OP_SPLIT, 8'h11);

   typedef struct {
      logic          we;
      logic [AW-1:0] wa;
      logic [W-1:0]  wd;
      logic [1:0]    v;
      logic [AW-1:0] a0;
      logic [AW-1:0] a1;
      logic [1:0]    rdy;
      logic [W-1:0]  d0;
      logic [W-1:0]  d1;
   } row_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic write_enable = 1'b0;
   logic [AW-1:0] waddr = '0;
   logic [W-1:0] wdata = '0;
   logic [1:0] valid = '0;
   logic [1:0][AW-1:0] addr = '0;
   logic [1:0] ready;
   logic [1:0][W-1:0] data;

   logic [W-1:0] mem_m [2**AW];
   logic [1:0] m_ready = '0;
   logic [1:0][W-1:0] m_data = '0;
   logic [1:0][W-1:0] m_val = '0;
   int m_ptr = 0;
   logic [1:0] lr = '0;
   int n_tests = 0;
   int n_fail = 0;
   row_t tbl [17];

   always #5 clk = ~clk;

   instruction_memory_responder #(
      .NUM_PORTS(N), .MEMORY_WIDTH(W), .MEMORY_ADDR_WIDTH(AW), .MEMORY_DEPTH(DEPTH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .memory_valid (valid),
      .memory_addr  (addr),
      .memory_ready (ready),
      .memory_data  (data),
      .write_enable (write_enable),
      .write_addr   (waddr),
      .write_data   (wdata)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [W-1:0] rd_m(input logic [AW-1:0] a);
      return (int'(a) < DEPTH) ? mem_m[a] : '0;
   endfunction

   // one clock edge of the responder as described: land pending data, arbitrate, then write
   task automatic model_edge();
      logic [1:0] nr = '0;
      bit done = 0;
      for (int p = 0; p < N; p++)
         if (m_ready[p]) m_data[p] = m_val[p];
      if (!write_enable)
         for (int k = 0; k < N; k++) begin
            int p = (m_ptr + k) % N;
            if (!done && valid[p] && !m_ready[p]) begin
               done = 1;
               nr[p] = 1'b1;
               m_val[p] = rd_m(addr[p]);
               m_ptr = (p + 1) % N;
            end
         end
      if (write_enable && int'(waddr) < DEPTH) mem_m[waddr] = wdata;
      m_ready = nr;
   endtask

   task automatic model_reset();
      m_ready = '0;
      m_data = '0;
      m_ptr = 0;
   endtask

   task automatic cyc(input bit check);
      if (check) begin
         chk("ready", 32'(ready), 32'(m_ready));
         chk("data0", 32'(data[0]), 32'(m_data[0]));
         chk("data1", 32'(data[1]), 32'(m_data[1]));
      end
      @(posedge clk);
      model_edge();
      #1;
   endtask

   initial begin
      tbl[0]  = '{1'b1, 11'h0AB, SPLIT_W,  2'b00, 11'h000, 11'h000, 2'b00, 16'h0000, 16'h0000};
      tbl[1]  = '{1'b1, 11'h010, 16'h1234, 2'b00, 11'h000, 11'h000, 2'b00, 16'h0000, 16'h0000};
      tbl[2]  = '{1'b1, 11'h020, 16'h5678, 2'b00, 11'h000, 11'h000, 2'b00, 16'h0000, 16'h0000};
      tbl[3]  = '{1'b1, 11'h400, 16'hBEEF, 2'b00, 11'h000, 11'h000, 2'b00, 16'h0000, 16'h0000};
      tbl[4]  = '{1'b0, 11'h000, 16'h0000, 2'b11, 11'h010, 11'h020, 2'b00, 16'h0000, 16'h0000};
      tbl[5]  = '{1'b0, 11'h000, 16'h0000, 2'b11, 11'h010, 11'h020, 2'b01, 16'h0000, 16'h0000};
      tbl[6]  = '{1'b0, 11'h000, 16'h0000, 2'b10, 11'h010, 11'h020, 2'b10, 16'h1234, 16'h0000};
      tbl[7]  = '{1'b0, 11'h000, 16'h0000, 2'b00, 11'h010, 11'h020, 2'b00, 16'h1234, 16'h5678};
      tbl[8]  = '{1'b0, 11'h000, 16'h0000, 2'b01, 11'h0AB, 11'h020, 2'b00, 16'h1234, 16'h5678};
      tbl[9]  = '{1'b0, 11'h000, 16'h0000, 2'b01, 11'h0AB, 11'h020, 2'b01, 16'h1234, 16'h5678};
      tbl[10] = '{1'b0, 11'h000, 16'h0000, 2'b00, 11'h0AB, 11'h020, 2'b00, SPLIT_W,  16'h5678};
      tbl[11] = '{1'b0, 11'h000, 16'h0000, 2'b01, 11'h7FF, 11'h020, 2'b00, SPLIT_W,  16'h5678};
      tbl[12] = '{1'b0, 11'h000, 16'h0000, 2'b01, 11'h7FF, 11'h020, 2'b01, SPLIT_W,  16'h5678};
      tbl[13] = '{1'b0, 11'h000, 16'h0000, 2'b00, 11'h7FF, 11'h020, 2'b00, 16'h0000, 16'h5678};
      tbl[14] = '{1'b0, 11'h000, 16'h0000, 2'b10, 11'h7FF, 11'h400, 2'b00, 16'h0000, 16'h5678};
      tbl[15] = '{1'b0, 11'h000, 16'h0000, 2'b10, 11'h7FF, 11'h400, 2'b10, 16'h0000, 16'h5678};
      tbl[16] = '{1'b0, 11'h000, 16'h0000, 2'b00, 11'h7FF, 11'h400, 2'b00, 16'h0000, 16'h0000};

      repeat (2) @(posedge clk);
      #1;
      chk("reset ready", 32'(ready), 32'h0);
      chk("reset data0", 32'(data[0]), 32'h0);
      chk("reset data1", 32'(data[1]), 32'h0);
      @(negedge clk) reset = 1'b1;
      @(posedge clk);
      #1;

      // RAM powers up undefined, so give every implemented word a known value first
      write_enable = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         waddr = AW'(i);
         wdata = W'($urandom);
         cyc(0);
      end
      write_enable = 1'b0;

      for (int i = 0; i < 17; i++) begin
         write_enable = tbl[i].we;
         waddr = tbl[i].wa;
         wdata = tbl[i].wd;
         valid = tbl[i].v;
         addr[0] = tbl[i].a0;
         addr[1] = tbl[i].a1;
         chk($sformatf("tbl%0d ready", i), 32'(ready), 32'(tbl[i].rdy));
         chk($sformatf("tbl%0d data0", i), 32'(data[0]), 32'(tbl[i].d0));
         chk($sformatf("tbl%0d data1", i), 32'(data[1]), 32'(tbl[i].d1));
         @(posedge clk);
         model_edge();
         #1;
      end
      write_enable = 1'b0;

      valid = 2'b11;
      addr[0] = 11'h0AB;
      addr[1] = 11'h010;
      for (int k = 0; k < 17; k++) begin
         chk($sformatf("rr%0d ready", k), 32'(ready), k == 0 ? 32'h0 : (k % 2 == 1 ? 32'h1 : 32'h2));
         cyc(1);
      end
      valid = 2'b00;
      repeat (3) cyc(1);
      chk("rr data0", 32'(data[0]), 32'(SPLIT_W));
      chk("rr data1", 32'(data[1]), 32'h1234);

      valid = 2'b10;
      addr[1] = 11'h050;
      write_enable = 1'b1;
      waddr = 11'h050;
      for (int k = 0; k < 3; k++) begin
         wdata = k == 0 ? 16'hAAAA : (k == 1 ? 16'hBBBB : 16'hCCCC);
         chk($sformatf("wr%0d ready", k), 32'(ready), 32'h0);
         cyc(1);
      end
      write_enable = 1'b0;
      chk("wr end ready", 32'(ready), 32'h0);
      cyc(1);
      chk("wr grant ready", 32'(ready), 32'h2);
      cyc(1);
      valid = 2'b00;
      chk("wr data1", 32'(data[1]), 32'hCCCC);
      cyc(1);

      valid = 2'b01;
      addr[0] = 11'h0AB;
      #2 reset = 1'b0;
      #1;
      chk("rst ready", 32'(ready), 32'h0);
      chk("rst data0", 32'(data[0]), 32'h0);
      chk("rst data1", 32'(data[1]), 32'h0);
      @(posedge clk);
      #1;
      chk("rst hold ready", 32'(ready), 32'h0);
      #3 reset = 1'b1;
      model_reset();
      @(posedge clk);
      model_edge();
      #1;
      chk("rerequest ready", 32'(ready), 32'h1);
      cyc(1);
      valid = 2'b00;
      chk("rerequest data0", 32'(data[0]), 32'(SPLIT_W));
      cyc(1);

      for (int t = 0; t < 800; t++) begin
         for (int p = 0; p < N; p++)
            if (!valid[p] || lr[p]) begin
               valid[p] = $urandom_range(0, 2) != 0;
               addr[p] = AW'($urandom_range(0, 1100));
            end
         lr = m_ready;
         write_enable = $urandom_range(0, 7) == 0;
         waddr = AW'($urandom_range(0, 1100));
         wdata = W'($urandom);
         cyc(1);
      end
      valid = 2'b00;
      write_enable = 1'b0;
      repeat (3) cyc(1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
